// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared owner codes, access sizes and request bus layout
package sram_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_cmd_t;

  typedef struct packed {
    logic      req;
    sram_cmd_t cmd;
  } sram_req_t;

  localparam int SRAM_REQ_BUS_WD = $bits(sram_req_t);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } arb_state_t;

endpackage

// File: rtl/sram_owner_fifo.sv
// sram_owner_fifo: in-order record of which master owns each outstanding transaction
module sram_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_din,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // owner storage; contents are don't-care until written, so no reset
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // pointers wrap naturally because depth is a power of two
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like port between inst fetch and data access
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_inst_req,
  input  logic        i_inst_wr,
  input  logic [1:0]  i_inst_size,
  input  logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_wdata,
  output logic        o_inst_addr_ok,
  output logic        o_inst_data_ok,
  output logic [31:0] o_inst_rdata,
  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [1:0]  i_data_size,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_addr_ok,
  output logic        o_data_data_ok,
  output logic [31:0] o_data_rdata,
  output logic        o_mem_req,
  output logic        o_mem_wr,
  output logic [1:0]  o_mem_size,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_addr_ok,
  input  logic        i_mem_data_ok,
  input  logic [31:0] i_mem_rdata,
  output logic        o_proto_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t r_state, w_state_nxt;
  logic       r_lock_owner, w_lock_owner_nxt;
  logic [SW-1:0] r_starve_cnt, w_starve_cnt_nxt;
  logic       r_proto_err;
  sram_req_t  w_inst_bus, w_data_bus;
  sram_cmd_t  w_grant;
  logic       w_owner;
  logic       w_mem_req;
  logic       w_accept;
  logic       w_inst_accept;
  logic       w_fifo_full, w_fifo_empty, w_fifo_head;
  logic       w_resp_ok;

  assign w_inst_bus = {i_inst_req, i_inst_wr, i_inst_size, i_inst_addr, i_inst_wdata};
  assign w_data_bus = {i_data_req, i_data_wr, i_data_size, i_data_addr, i_data_wdata};

  // grant: locked owner in HOLD, otherwise data first unless inst has starved
  always_comb begin
    w_owner = (r_state == ST_HOLD) ? r_lock_owner :
              (w_inst_bus.req && r_starve_cnt == STARVE_MAX) ? OWNER_INST :
              w_data_bus.req ? OWNER_DATA : OWNER_INST;
    w_grant = (w_owner == OWNER_DATA) ? w_data_bus.cmd : w_inst_bus.cmd;
  end

  // a full owner FIFO blocks new address phases even if a pop lands this cycle
  assign w_mem_req     = (w_inst_bus.req | w_data_bus.req) & ~w_fifo_full;
  assign w_accept      = w_mem_req & i_mem_addr_ok;
  assign w_inst_accept = w_accept & (w_owner == OWNER_INST);

  assign o_mem_req   = w_mem_req;
  assign o_mem_wr    = w_grant.wr;
  assign o_mem_size  = w_grant.size;
  assign o_mem_addr  = w_grant.addr;
  assign o_mem_wdata = w_grant.wdata;

  assign o_inst_addr_ok = w_inst_accept;
  assign o_data_addr_ok = w_accept & (w_owner == OWNER_DATA);

  sram_owner_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_owner_fifo (
    .i_clk   (i_clk),
    .i_resetn(i_resetn),
    .i_push  (w_accept),
    .i_pop   (i_mem_data_ok),
    .i_din   (w_owner),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head)
  );

  // a response with nothing outstanding is dropped and flagged
  assign w_resp_ok      = i_mem_data_ok & ~w_fifo_empty;
  assign o_inst_data_ok = w_resp_ok & (w_fifo_head == OWNER_INST);
  assign o_data_data_ok = w_resp_ok & (w_fifo_head == OWNER_DATA);
  assign o_inst_rdata   = i_mem_rdata;
  assign o_data_rdata   = i_mem_rdata;
  assign o_proto_err    = r_proto_err;

  // next state: lock the owner while memory stalls, track inst starvation
  always_comb begin
    w_state_nxt      = r_state;
    w_lock_owner_nxt = r_lock_owner;
    if (r_state == ST_IDLE && w_mem_req && !i_mem_addr_ok) begin
      w_state_nxt      = ST_HOLD;
      w_lock_owner_nxt = w_owner;
    end else if (r_state == ST_HOLD && w_accept) begin
      w_state_nxt = ST_IDLE;
    end
    w_starve_cnt_nxt = (!i_inst_req || w_inst_accept) ? '0 :
                       (r_starve_cnt == STARVE_MAX) ? r_starve_cnt : r_starve_cnt + 1'b1;
  end

  // arbitration state registers and sticky protocol error
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= ST_IDLE;
      r_lock_owner <= OWNER_INST;
      r_starve_cnt <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_owner <= w_lock_owner_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_proto_err  <= r_proto_err | (i_mem_data_ok & w_fifo_empty);
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random checks of sram_arbiter against a queue-based model
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int OUTSTANDING  = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        proto_err;

  int tests = 0;
  int fails = 0;

  bit mq[$];
  int m_starve;
  bit m_locked, m_lock_own, m_perr;
  bit last_iaok;

  always #5 clk = ~clk;

  sram_arbiter #(
    .OUTSTANDING (OUTSTANDING),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .i_clk         (clk),
    .i_resetn      (resetn),
    .i_inst_req    (inst_req),
    .i_inst_wr     (inst_wr),
    .i_inst_size   (inst_size),
    .i_inst_addr   (inst_addr),
    .i_inst_wdata  (inst_wdata),
    .o_inst_addr_ok(inst_addr_ok),
    .o_inst_data_ok(inst_data_ok),
    .o_inst_rdata  (inst_rdata),
    .i_data_req    (data_req),
    .i_data_wr     (data_wr),
    .i_data_size   (data_size),
    .i_data_addr   (data_addr),
    .i_data_wdata  (data_wdata),
    .o_data_addr_ok(data_addr_ok),
    .o_data_data_ok(data_data_ok),
    .o_data_rdata  (data_rdata),
    .o_mem_req     (mem_req),
    .o_mem_wr      (mem_wr),
    .o_mem_size    (mem_size),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_addr_ok (mem_addr_ok),
    .i_mem_data_ok (mem_data_ok),
    .i_mem_rdata   (mem_rdata),
    .o_proto_err   (proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] rsize();
    int r;
    r = $urandom_range(2, 0);
    return (r == 0) ? SIZE_BYTE : (r == 1) ? SIZE_HALF : SIZE_WORD;
  endfunction

  task automatic mreset();
    mq.delete();
    m_starve   = 0;
    m_locked   = 0;
    m_lock_own = 0;
    m_perr     = 0;
    last_iaok  = 0;
  endtask

  // one cycle: predict from the queue model, compare, clock, advance the model
  task automatic step();
    bit full, mreq, own, acc, idok, ddok;
    #1;
    full = mq.size() == OUTSTANDING;
    mreq = (inst_req || data_req) && !full;
    own  = m_locked ? m_lock_own : (inst_req && m_starve == STARVE_LIMIT) ? 1'b0 : data_req;
    acc  = mreq && mem_addr_ok;
    idok = mem_data_ok && mq.size() != 0 && mq[0] == 1'b0;
    ddok = mem_data_ok && mq.size() != 0 && mq[0] == 1'b1;
    chk("mem_req", mem_req, mreq);
    if (mreq) begin
      chk("mem_addr", mem_addr, own ? data_addr : inst_addr);
      chk("mem_wdata", mem_wdata, own ? data_wdata : inst_wdata);
      chk("mem_wr", mem_wr, own ? data_wr : inst_wr);
      chk("mem_size", mem_size, own ? data_size : inst_size);
    end
    chk("inst_addr_ok", inst_addr_ok, acc && !own);
    chk("data_addr_ok", data_addr_ok, acc && own);
    chk("inst_data_ok", inst_data_ok, idok);
    chk("data_data_ok", data_data_ok, ddok);
    if (idok) chk("inst_rdata", inst_rdata, mem_rdata);
    if (ddok) chk("data_rdata", data_rdata, mem_rdata);
    chk("proto_err", proto_err, m_perr);
    last_iaok = acc && !own;
    @(posedge clk);
    if (mem_data_ok) begin
      if (mq.size() != 0) void'(mq.pop_front());
      else m_perr = 1;
    end
    if (acc) mq.push_back(own);
    if (mreq && !mem_addr_ok) begin
      m_locked   = 1;
      m_lock_own = own;
    end else if (acc) m_locked = 0;
    m_starve = (inst_req && !last_iaok) ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve) : 0;
    @(negedge clk);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if (!inst_req || last_iaok) begin
        inst_req = ($urandom % 3) != 0;
        inst_wr = $urandom; inst_size = rsize(); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!data_req || data_addr_ok) begin
        data_req = ($urandom % 3) != 0;
        data_wr = $urandom; data_size = rsize(); data_addr = $urandom; data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom % 4) != 0;
      mem_data_ok = mq.size() != 0 && ($urandom % 3) != 0;
      mem_rdata   = $urandom;
      step();
    end
  endtask

  initial begin
    int n1, n2;
    resetn = 0;
    inst_req = 0; inst_wr = 0; inst_size = SIZE_WORD; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = SIZE_WORD; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    chk("rst_proto_err", proto_err, 0);
    resetn = 1;

    // single inst read
    inst_req = 1; inst_addr = 32'hBFC00000; mem_addr_ok = 1;
    #1 chk("t1_addr_ok", inst_addr_ok, 1);
    chk("t1_mem_addr", mem_addr, 32'hBFC00000);
    step();
    inst_req = 0; mem_addr_ok = 0;
    step();
    mem_data_ok = 1; mem_rdata = 32'h24010001;
    #1 chk("t1_data_ok", inst_data_ok, 1);
    chk("t1_rdata", inst_rdata, 32'h24010001);
    chk("t1_no_data_dok", data_data_ok, 0);
    step();
    mem_data_ok = 0;

    // simultaneous requests: data first, then inst
    inst_req = 1; inst_addr = 32'h00001000; data_req = 1; data_addr = 32'h00002000; mem_addr_ok = 1;
    #1 chk("t2_data_first", data_addr_ok, 1);
    chk("t2_inst_wait", inst_addr_ok, 0);
    step();
    data_req = 0;
    #1 chk("t2_inst_next", inst_addr_ok, 1);
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11111111;
    #1 chk("t2_resp_data", data_data_ok, 1);
    step();
    mem_rdata = 32'h22222222;
    #1 chk("t2_resp_inst", inst_data_ok, 1);
    step();
    mem_data_ok = 0;

    // HOLD: stalled inst keeps the port while data waits
    inst_req = 1; inst_addr = 32'hC0000004; mem_addr_ok = 0;
    step();
    data_req = 1; data_addr = 32'hD0000008;
    #1 chk("t3_hold_addr1", mem_addr, 32'hC0000004);
    step();
    #1 chk("t3_hold_addr2", mem_addr, 32'hC0000004);
    step();
    mem_addr_ok = 1;
    #1 chk("t3_inst_acc", inst_addr_ok, 1);
    step();
    inst_req = 0;
    #1 chk("t3_data_acc", data_addr_ok, 1);
    chk("t3_data_addr", mem_addr, 32'hD0000008);
    step();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    step();
    step();
    mem_data_ok = 0;

    // starvation: inst wins on its 5th request cycle, then again 5 cycles later
    inst_req = 1; data_req = 1; mem_addr_ok = 1; n1 = 0; n2 = 0;
    for (int c = 1; c <= 12; c++) begin
      mem_data_ok = mq.size() != 0;
      mem_rdata = $urandom;
      step();
      if (last_iaok) begin
        if (n1 == 0) n1 = c;
        else if (n2 == 0) n2 = c;
      end
    end
    chk("t4_first_win", n1, 5);
    chk("t4_second_win", n2, 10);
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    step();
    mem_data_ok = 0;

    // owner FIFO full blocks mem_req, no bypass on same-cycle pop
    data_req = 1; data_addr = 32'h0000A000; mem_addr_ok = 1;
    step();
    step();
    #1 chk("t5_full_req", mem_req, 0);
    chk("t5_full_aok", data_addr_ok, 0);
    step();
    mem_data_ok = 1;
    #1 chk("t5_pop_no_bypass", mem_req, 0);
    chk("t5_pop_dok", data_data_ok, 1);
    step();
    mem_data_ok = 0;
    #1 chk("t5_reassert", mem_req, 1);
    step();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    step();
    step();
    mem_data_ok = 0;

    // response with nothing outstanding
    mem_data_ok = 1;
    #1 chk("t6_no_inst_dok", inst_data_ok, 0);
    chk("t6_no_data_dok", data_data_ok, 0);
    step();
    mem_data_ok = 0;
    #1 chk("t6_proto_err", proto_err, 1);
    step();

    rand_phase(1500);

    // asynchronous reset mid-burst
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #2 resetn = 0;
    #1 chk("rst2_proto_err", proto_err, 0);
    chk("rst2_mem_req", mem_req, 0);
    chk("rst2_inst_dok", inst_data_ok, 0);
    chk("rst2_data_dok", data_data_ok, 0);
    chk("rst2_inst_aok", inst_addr_ok, 0);
    chk("rst2_data_aok", data_addr_ok, 0);
    @(negedge clk);
    mem_data_ok = 0;
    resetn = 1;
    mreset();
    rand_phase(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master arbiter that shares one SRAM-like memory port between the CPU's instruction-fetch and data-access requesters. Sits between the pipeline's `inst_sram_*`/`data_sram_*` side and a single unified memory port. Grants one address phase per cycle, tracks outstanding transactions in order, and routes each returned read/write acknowledgement to its owner.

## Interface
- `OUTSTANDING`, 2: max accepted-but-unanswered transactions (power of 2, ≥2).
- `STARVE_LIMIT`, 4: consecutive cycles inst may lose arbitration before it is forced to win.

Clock and reset (decided): one clock; reset is asynchronous and active-low.
- `clk` in 1: sole clock, all state on posedge.
- `resetn` in 1: asynchronous, active-low reset.

Requester side, for each m in {`inst`, `data`}:
- `m_req` in 1: request valid.
- `m_wr` in 1: 1 = write.
- `m_size` in 2: 0 = byte, 1 = half, 2 = word.
- `m_addr` in 32: address.
- `m_wdata` in 32: write data.
- `m_addr_ok` out 1: address phase accepted this cycle.
- `m_data_ok` out 1: response for this master's oldest transaction.
- `m_rdata` out 32: read data, valid with `m_data_ok`.

Memory side:
- `mem_req`, `mem_wr`, `mem_size`, `mem_addr`, `mem_wdata`: out, widths as above.
- `mem_addr_ok` in 1: memory accepts the address phase.
- `mem_data_ok` in 1: memory returns one response, in order.
- `mem_rdata` in 32: read data.
- `proto_err` out 1: sticky, set on `mem_data_ok` with no outstanding transaction.

## Operation
- **States:** `IDLE` (no locked grant) and `HOLD` (owner locked because `mem_req` was high without `mem_addr_ok`).
- **IDLE arbitration:**
  - Data has priority over inst.
  - Exception: when `starve_cnt == STARVE_LIMIT` and `inst_req` is high, inst wins.
- **Starvation counter:**
  - `starve_cnt` increments when `inst_req` is high and inst is not accepted. It saturates at `STARVE_LIMIT`.
  - It clears when inst gets an `addr_ok`, or when `inst_req` is low.
- **mem_req:** `mem_req = (inst_req | data_req) & ~fifo_full`. Memory-side fields are a mux of the granted master.
- **Entering HOLD:** if `mem_req` is high and `mem_addr_ok` is low, go to HOLD with the owner latched.
  - In HOLD the mux stays on the locked owner, even if the other master asserts `req`.
  - Exit to IDLE on `mem_addr_ok`.
- **Requester rule:** a requester holds `req` and all fields stable until its `addr_ok`. The arbiter does not check this.
- **Accept:** `m_addr_ok = mem_addr_ok & mem_req & (owner == m)`. On accept, push owner into the owner FIFO.
- **Response:** on `mem_data_ok`, pop the FIFO head. Drive `head_data_ok`, with `head_rdata = mem_rdata`. The other master's `data_ok` stays 0.
- **FIFO full:** when `fifo_full`, `mem_req = 0`. This holds even if a pop occurs the same cycle (no full-bypass).
- **Simultaneous push and pop (not full):** count unchanged, order preserved.
- **Pointers:** wrap modulo `OUTSTANDING`. Count width is `$clog2(OUTSTANDING)+1`.
- **Pop while empty:** ignore the pop, no `data_ok` to either master, set `proto_err` (sticky until reset).

## Timing
- All requester/memory handshake outputs are combinational from current inputs plus registered state. Zero added latency: `m_req` → `mem_req` in the same cycle, `mem_addr_ok` → `m_addr_ok` in the same cycle, `mem_data_ok` → `m_data_ok` in the same cycle.
- Registered state: `state`, `lock_owner`, `starve_cnt`, FIFO storage, pointers, count, `proto_err`.
- Reset (async assert, sync-safe deassert via the top-level flop):
  - State goes to IDLE, FIFO empty, `starve_cnt = 0`, `proto_err = 0`.
  - All `*_addr_ok` and `*_data_ok` are 0; `mem_req = 0` while both reqs are low.
- Reset mid-transaction discards outstanding entries. The memory must be reset together with the arbiter.
- Throughput: one accept per cycle, one response per cycle.

## Structure
- Shared header macros:
  - `OWNER_INST = 1'b0`, `OWNER_DATA = 1'b1`.
  - `SIZE_BYTE/HALF/WORD`.
  - `SRAM_REQ_BUS_WD` (2+2+32+32 = 68 bits: req, wr, size, addr, wdata).
- Sub-module `sram_owner_fifo`: parameterised depth, 1-bit entries, `push`/`pop`/`full`/`empty`/`head`.
- Arbitration FSM and mux live in `sram_arbiter`.

## Test plan
- **Single inst read:** `inst_req=1`, addr `0xBFC00000`, memory accepts at once and returns `0x24010001` two cycles later → `inst_addr_ok` for 1 cycle, then `inst_data_ok` with `inst_rdata=0x24010001`; `data_data_ok` stays 0.
- **Simultaneous requests:** both requests in the same cycle, `mem_addr_ok=1` → data accepted first, inst the next cycle; responses return data then inst, routed correctly.
- **HOLD lock:** inst req with `mem_addr_ok=0` for 3 cycles while data_req rises in cycle 2 → `mem_addr` stays at the inst address until accept; data is served afterwards.
- **Starvation:** `data_req` held continuously with `STARVE_LIMIT=4` → inst accepted on its 5th request cycle; `starve_cnt` returns to 0.
- **FIFO full:** `OUTSTANDING=2`, memory withholds `data_ok` → after 2 accepts `mem_req=0`; one `mem_data_ok` → `mem_req` reasserts the next cycle.
- **Protocol error / reset:** `mem_data_ok` pulsed with the FIFO empty → no `m_data_ok` to either master, `proto_err=1`; asserting `resetn=0` mid-burst → all outputs 0 and `proto_err` cleared immediately.
